secuenciador_salto: RTL and testbench

Branch and sequencing controller that drives the program counter's write-enable, conditional-jump, unconditional-jump and jump-target inputs. Each instruction passes through a fixed four-state fetch/decode/evaluate/update cycle. The block evaluates branch conditions against the ALU status flags and presents the next-PC decision to the program counter. An optional return-address stack supports CALL/RET.

---
 rtl/secuenciador_salto.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_secuenciador_salto.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_salto.sv
// -----------------------------------------------------------------------------
// secuenciador_salto
//
// Branch and sequencing controller for the program counter. Every instruction
// walks through FETCH -> DECODE -> EVAL -> UPDATE. The jump decision is taken
// at the end of EVAL (FLAGS sampled there) and presented to the PC during
// UPDATE, which the PC captures on the falling edge.
//
// Optional feature: define SECUENCIADOR_CALL_STACK_EN to build a STACK_DEPTH x
// 11-bit return-address LIFO for CALL/RET. Without it CALL acts as B, RET acts
// as a sequential opcode and STACK_ERR is tied low.
//
// Ports:
//   CLK        in   clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   RUN        in   level; starts sequencing, falling lets the current
//                   instruction finish before returning to IDLE
//   OPCODE     in   [4:0]  opcode, sampled at the end of DECODE
//   COND       in   [3:0]  branch condition, sampled at the end of DECODE
//   TARGET     in   [10:0] jump target, sampled at the end of DECODE
//   PC_IN      in   [10:0] current PC, sampled at the end of DECODE
//   FLAGS      in   [3:0]  {Z, N, C, OV}, sampled at the end of EVAL
//   WPC        out  PC write-enable, one cycle per executed instruction
//   ALU_JMP    out  taken conditional branch (only while WPC=1)
//   UC_JMP     out  taken unconditional jump (only while WPC=1)
//   DOUT       out  [10:0] jump target (0 unless a jump is taken)
//   BUSY       out  high in every state except IDLE and HALT
//   HALTED     out  high in HALT
//   STACK_ERR  out  sticky stack overflow/underflow flag
//   state_dbg  out  [2:0] current FSM state encoding, for observation only
//
// Interface protocol: there is no valid/ready handshake. RUN is a level; the
// instruction fields only need to be stable across the edge that leaves
// DECODE, and FLAGS across the edge that leaves EVAL.
// -----------------------------------------------------------------------------
module secuenciador_salto #(
    parameter int STACK_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        RUN,
    input  logic [4:0]  OPCODE,
    input  logic [3:0]  COND,
    input  logic [10:0] TARGET,
    input  logic [10:0] PC_IN,
    input  logic [3:0]  FLAGS,
    output logic        WPC,
    output logic        ALU_JMP,
    output logic        UC_JMP,
    output logic [10:0] DOUT,
    output logic        BUSY,
    output logic        HALTED,
    output logic        STACK_ERR,
    output logic [2:0]  state_dbg
);

    localparam logic [4:0] OP_B     = 5'h10;
    localparam logic [4:0] OP_BCOND = 5'h11;
    localparam logic [4:0] OP_CALL  = 5'h12;
    localparam logic [4:0] OP_RET   = 5'h13;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EVAL   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Elaboration-time guard on the stack depth range.
    if (STACK_DEPTH < 2 || STACK_DEPTH > 8) begin : g_depth_check
        $error("secuenciador_salto: STACK_DEPTH must be in 2..8");
    end

    state_t      state;
    logic [4:0]  op_q;
    logic [3:0]  cond_q;
    logic [10:0] target_q;

    logic        z_f, n_f, c_f, ov_f;
    logic        cond_taken;
    logic        dec_alu;
    logic        dec_uc;
    logic [10:0] dec_dout;

    assign {z_f, n_f, c_f, ov_f} = FLAGS;
    assign state_dbg = state;

`ifdef SECUENCIADOR_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [10:0]     stack_mem [STACK_DEPTH];
    logic [SP_W-1:0] sp;            // number of valid entries
    logic [10:0]     pc_q;
    logic            push_q;
    logic            pop_q;
    logic            stack_full;
    logic            stack_empty;
    logic [10:0]     stack_top;
    logic            dec_push;
    logic            dec_pop;
    logic            dec_err;

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    // Only read when the stack is non-empty, so the wrap at sp=0 is harmless.
    assign stack_top   = stack_mem[IDX_W'(sp - 1'b1)];
`else
    logic unused_pc;
    assign unused_pc = ^PC_IN;
    assign STACK_ERR = 1'b0;
`endif

    // Condition evaluation uses the live FLAGS; it only matters on the edge
    // that leaves EVAL, which is where FLAGS is defined to be sampled.
    always_comb begin
        cond_taken = 1'b0;
        case (cond_q)
            4'd0:    cond_taken = z_f;
            4'd1:    cond_taken = ~z_f;
            4'd2:    cond_taken = n_f ^ ov_f;
            4'd3:    cond_taken = z_f | (n_f ^ ov_f);
            4'd4:    cond_taken = ~z_f & ~(n_f ^ ov_f);
            4'd5:    cond_taken = ~(n_f ^ ov_f);
            4'd6:    cond_taken = c_f;
            4'd7:    cond_taken = ~c_f;
            default: cond_taken = 1'b0;
        endcase
    end

    // Next-PC decision from the registered instruction fields.
    always_comb begin
        dec_alu  = 1'b0;
        dec_uc   = 1'b0;
        dec_dout = '0;
`ifdef SECUENCIADOR_CALL_STACK_EN
        dec_push = 1'b0;
        dec_pop  = 1'b0;
        dec_err  = 1'b0;
`endif
        case (op_q)
            OP_B: begin
                dec_uc   = 1'b1;
                dec_dout = target_q;
            end
            OP_BCOND: begin
                if (cond_taken) begin
                    dec_alu  = 1'b1;
                    dec_dout = target_q;
                end
            end
            OP_CALL: begin
                // The jump is taken even when the return address cannot be kept.
                dec_uc   = 1'b1;
                dec_dout = target_q;
`ifdef SECUENCIADOR_CALL_STACK_EN
                if (stack_full) dec_err  = 1'b1;
                else            dec_push = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef SECUENCIADOR_CALL_STACK_EN
                // An empty-stack RET degrades to a sequential step.
                if (stack_empty) begin
                    dec_err = 1'b1;
                end else begin
                    dec_uc   = 1'b1;
                    dec_dout = stack_top;
                    dec_pop  = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    // Main FSM. Outputs are registered for the state being entered, so WPC and
    // the jump fields appear exactly for the UPDATE cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            op_q     <= '0;
            cond_q   <= '0;
            target_q <= '0;
            WPC      <= 1'b0;
            ALU_JMP  <= 1'b0;
            UC_JMP   <= 1'b0;
            DOUT     <= '0;
            BUSY     <= 1'b0;
            HALTED   <= 1'b0;
        end else begin
            WPC     <= 1'b0;
            ALU_JMP <= 1'b0;
            UC_JMP  <= 1'b0;
            DOUT    <= '0;
            case (state)
                S_IDLE: begin
                    if (RUN) begin
                        state <= S_FETCH;
                        BUSY  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q     <= OPCODE;
                    cond_q   <= COND;
                    target_q <= TARGET;
                    state    <= S_EVAL;
                end
                S_EVAL: begin
                    if (op_q == OP_HALT) begin
                        state  <= S_HALT;
                        BUSY   <= 1'b0;
                        HALTED <= 1'b1;
                    end else begin
                        state   <= S_UPDATE;
                        WPC     <= 1'b1;
                        ALU_JMP <= dec_alu;
                        UC_JMP  <= dec_uc;
                        DOUT    <= dec_dout;
                    end
                end
                S_UPDATE: begin
                    if (RUN) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state  <= S_IDLE;
                    BUSY   <= 1'b0;
                    HALTED <= 1'b0;
                end
            endcase
        end
    end

`ifdef SECUENCIADOR_CALL_STACK_EN
    // Return-address stack. The push/pop decided in EVAL is committed while
    // UPDATE is presented, so the next instruction sees the new top.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sp        <= '0;
            pc_q      <= '0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            STACK_ERR <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            case (state)
                S_DECODE: begin
                    pc_q <= PC_IN;
                end
                S_EVAL: begin
                    push_q <= dec_push;
                    pop_q  <= dec_pop;
                    if (dec_err) STACK_ERR <= 1'b1;
                end
                S_UPDATE: begin
                    if (push_q) begin
                        // 11-bit add wraps 2047 to 0.
                        stack_mem[IDX_W'(sp)] <= pc_q + 11'd1;
                        sp <= sp + 1'b1;
                    end else if (pop_q) begin
                        sp <= sp - 1'b1;
                    end
                    push_q <= 1'b0;
                    pop_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_secuenciador_salto.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_salto
//
// Directed bench for secuenciador_salto. A table of single instructions with
// hand-computed UPDATE outputs is run back to back with RUN held high, followed
// by hand-written sequences for CALL/RET, RUN release, asynchronous reset and
// HALT. The call/return section follows SECUENCIADOR_CALL_STACK_EN.
// -----------------------------------------------------------------------------
module tb_secuenciador_salto;

    logic        CLK;
    logic        RESET_N;
    logic        RUN;
    logic [4:0]  OPCODE;
    logic [3:0]  COND;
    logic [10:0] TARGET;
    logic [10:0] PC_IN;
    logic [3:0]  FLAGS;
    logic        WPC;
    logic        ALU_JMP;
    logic        UC_JMP;
    logic [10:0] DOUT;
    logic        BUSY;
    logic        HALTED;
    logic        STACK_ERR;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  cond;
        logic [10:0] tgt;
        logic [10:0] pc;
        logic [3:0]  flags_pre;   // driven through FETCH/DECODE, must be ignored
        logic [3:0]  flags;       // driven during EVAL, decides the branch
        logic        alu;
        logic        uc;
        logic [10:0] dout;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    secuenciador_salto #(.STACK_DEPTH(4)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .RUN       (RUN),
        .OPCODE    (OPCODE),
        .COND      (COND),
        .TARGET    (TARGET),
        .PC_IN     (PC_IN),
        .FLAGS     (FLAGS),
        .WPC       (WPC),
        .ALU_JMP   (ALU_JMP),
        .UC_JMP    (UC_JMP),
        .DOUT      (DOUT),
        .BUSY      (BUSY),
        .HALTED    (HALTED),
        .STACK_ERR (STACK_ERR),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [3:0] cond,
                                input logic [10:0] tgt, input logic [10:0] pc,
                                input logic [3:0] fpre, input logic [3:0] fl,
                                input logic alu, input logic uc, input logic [10:0] dout);
        vec_t v;
        v.op = op; v.cond = cond; v.tgt = tgt; v.pc = pc;
        v.flags_pre = fpre; v.flags = fl;
        v.alu = alu; v.uc = uc; v.dout = dout;
        return v;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_wpc"},    WPC,       0);
        chk({tag, "_alu"},    ALU_JMP,   0);
        chk({tag, "_uc"},     UC_JMP,    0);
        chk({tag, "_dout"},   DOUT,      0);
        chk({tag, "_busy"},   BUSY,      0);
        chk({tag, "_halted"}, HALTED,    0);
        chk({tag, "_serr"},   STACK_ERR, 0);
        chk({tag, "_state"},  state_dbg, 0);
    endtask

    task automatic chk_quiet(input string tag, input logic busy_exp);
        chk({tag, "_wpc"},    WPC,     0);
        chk({tag, "_alu"},    ALU_JMP, 0);
        chk({tag, "_uc"},     UC_JMP,  0);
        chk({tag, "_dout"},   DOUT,    0);
        chk({tag, "_busy"},   BUSY,    busy_exp);
        chk({tag, "_halted"}, HALTED,  0);
    endtask

    // Reset asserted between edges, checked at once, released after an edge.
    task automatic do_reset(input string tag);
        @(posedge CLK);
        #3;
        RESET_N = 1'b0;
        RUN     = 1'b0;
        #1;
        chk_reset(tag);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    // One full instruction with RUN high. Starts right after an edge at which
    // the DUT is in IDLE or UPDATE; ends 1 time unit after the UPDATE edge.
    task automatic run_instr(input vec_t v, input string tag);
        OPCODE = v.op;
        COND   = v.cond;
        TARGET = v.tgt;
        PC_IN  = v.pc;
        FLAGS  = v.flags_pre;
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK);
            #1;
            if (k < 4) begin
                chk_quiet($sformatf("%s_c%0d", tag, k), 1'b1);
            end else begin
                chk({tag, "_wpc"},    WPC,     1);
                chk({tag, "_alu"},    ALU_JMP, v.alu);
                chk({tag, "_uc"},     UC_JMP,  v.uc);
                chk({tag, "_dout"},   DOUT,    v.dout);
                chk({tag, "_busy"},   BUSY,    1);
                chk({tag, "_halted"}, HALTED,  0);
            end
            if (k == 3) begin
                // In EVAL: instruction fields are already latched, flags are live.
                FLAGS  = v.flags;
                OPCODE = ~v.op;
                COND   = ~v.cond;
                TARGET = ~v.tgt;
                PC_IN  = ~v.pc;
            end
        end
        // Flag change after EVAL must not disturb anything.
        FLAGS = ~v.flags;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESET_N = 1'b0;
        RUN     = 1'b0;
        OPCODE  = '0;
        COND    = '0;
        TARGET  = '0;
        PC_IN   = '0;
        FLAGS   = '0;

        //             op     cond  tgt      pc       pre      flags    alu uc dout
        vecs[0]  = mk(5'h00, 4'h0, 11'h155, 11'h000, 4'b0000, 4'b0000, 0, 0, 11'h000);
        vecs[1]  = mk(5'h11, 4'h0, 11'h155, 11'h001, 4'b0000, 4'b1000, 1, 0, 11'h155);
        vecs[2]  = mk(5'h11, 4'h0, 11'h155, 11'h002, 4'b1000, 4'b0000, 0, 0, 11'h000);
        vecs[3]  = mk(5'h11, 4'h9, 11'h155, 11'h003, 4'b1111, 4'b1000, 0, 0, 11'h000);
        vecs[4]  = mk(5'h11, 4'h2, 11'h2AA, 11'h004, 4'b0000, 4'b0100, 1, 0, 11'h2AA);
        vecs[5]  = mk(5'h11, 4'h2, 11'h2AA, 11'h005, 4'b0100, 4'b0101, 0, 0, 11'h000);
        vecs[6]  = mk(5'h11, 4'h1, 11'h001, 11'h006, 4'b1000, 4'b0000, 1, 0, 11'h001);
        vecs[7]  = mk(5'h11, 4'h3, 11'h0AB, 11'h007, 4'b0001, 4'b0000, 0, 0, 11'h000);
        vecs[8]  = mk(5'h11, 4'h3, 11'h7FF, 11'h008, 4'b0000, 4'b0001, 1, 0, 11'h7FF);
        vecs[9]  = mk(5'h11, 4'h4, 11'h400, 11'h009, 4'b1000, 4'b0000, 1, 0, 11'h400);
        vecs[10] = mk(5'h11, 4'h4, 11'h400, 11'h00A, 4'b0000, 4'b1000, 0, 0, 11'h000);
        vecs[11] = mk(5'h11, 4'h5, 11'h123, 11'h00B, 4'b0100, 4'b0101, 1, 0, 11'h123);
        vecs[12] = mk(5'h11, 4'h6, 11'h0F0, 11'h00C, 4'b0000, 4'b0010, 1, 0, 11'h0F0);
        vecs[13] = mk(5'h11, 4'h7, 11'h0F0, 11'h00D, 4'b0000, 4'b0010, 0, 0, 11'h000);
        vecs[14] = mk(5'h11, 4'h7, 11'h00F, 11'h00E, 4'b0010, 4'b0000, 1, 0, 11'h00F);
        vecs[15] = mk(5'h11, 4'hF, 11'h3C3, 11'h00F, 4'b0000, 4'b1111, 0, 0, 11'h000);
        vecs[16] = mk(5'h10, 4'h0, 11'h321, 11'h010, 4'b0000, 4'b0000, 0, 1, 11'h321);
        vecs[17] = mk(5'h0F, 4'h0, 11'h555, 11'h011, 4'b1000, 4'b1000, 0, 0, 11'h000);
        vecs[18] = mk(5'h1E, 4'h3, 11'h555, 11'h012, 4'b0000, 4'b0001, 0, 0, 11'h000);
        vecs[19] = mk(5'h11, 4'h5, 11'h0AA, 11'h013, 4'b0000, 4'b0001, 0, 0, 11'h000);
        vecs[20] = mk(5'h11, 4'h3, 11'h0CC, 11'h014, 4'b0000, 4'b1000, 1, 0, 11'h0CC);

        // Reset state
        do_reset("reset");

        // RUN low: stays in IDLE
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk_quiet($sformatf("idle%0d", i), 1'b0);
        end

        // Table: back-to-back instructions, WPC every 4th cycle
        RUN = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            run_instr(vecs[i], $sformatf("v%0d", i));
        end

`ifdef SECUENCIADOR_CALL_STACK_EN
        // CALL at 2047 pushes 0; RET returns there
        run_instr(mk(5'h12, 4'h0, 11'h020, 11'h7FF, 4'b0000, 4'b0000, 0, 1, 11'h020), "call_wrap");
        chk("call_wrap_serr", STACK_ERR, 0);
        run_instr(mk(5'h13, 4'h0, 11'h0AA, 11'h020, 4'b0000, 4'b0000, 0, 1, 11'h000), "ret_wrap");
        // Five nested calls on a 4-deep stack
        for (int i = 0; i < 5; i++) begin
            run_instr(mk(5'h12, 4'h0, 11'h200 + 11'(i), 11'h100 + 11'(i),
                         4'b0000, 4'b0000, 0, 1, 11'h200 + 11'(i)), $sformatf("ncall%0d", i));
            chk($sformatf("ncall%0d_serr", i), STACK_ERR, (i == 4) ? 1 : 0);
        end
        run_instr(mk(5'h13, 4'h0, 11'h000, 11'h204, 4'b0000, 4'b0000, 0, 1, 11'h104), "ret_a");
        run_instr(mk(5'h13, 4'h0, 11'h000, 11'h103, 4'b0000, 4'b0000, 0, 1, 11'h103), "ret_b");
        chk("serr_sticky", STACK_ERR, 1);
        // Reset clears the error; RET on an empty stack is sequential + error
        do_reset("reset_stk");
        RUN = 1'b1;
        run_instr(mk(5'h13, 4'h0, 11'h0AA, 11'h050, 4'b0000, 4'b0000, 0, 0, 11'h000), "ret_empty");
        chk("ret_empty_serr", STACK_ERR, 1);
`else
        // Without the stack: CALL behaves as B, RET as sequential
        run_instr(mk(5'h12, 4'h0, 11'h020, 11'h7FF, 4'b0000, 4'b0000, 0, 1, 11'h020), "call_b");
        run_instr(mk(5'h13, 4'h0, 11'h0AA, 11'h021, 4'b0000, 4'b0000, 0, 0, 11'h000), "ret_seq");
        chk("nostack_serr", STACK_ERR, 0);
`endif

        // RUN dropped in DECODE: instruction completes, then IDLE
        OPCODE = 5'h10; COND = 4'h0; TARGET = 11'h0E1; PC_IN = 11'h030; FLAGS = 4'b0000;
        @(posedge CLK); #1; chk_quiet("drop_fetch", 1'b1);
        @(posedge CLK); #1; chk_quiet("drop_decode", 1'b1);
        RUN = 1'b0;
        @(posedge CLK); #1; chk_quiet("drop_eval", 1'b1);
        @(posedge CLK); #1;
        chk("drop_upd_wpc",  WPC,    1);
        chk("drop_upd_uc",   UC_JMP, 1);
        chk("drop_upd_dout", DOUT,   11'h0E1);
        @(posedge CLK); #1; chk_quiet("drop_idle0", 1'b0);
        @(posedge CLK); #1; chk_quiet("drop_idle1", 1'b0);
        chk("drop_idle_state", state_dbg, 0);

        // Asynchronous reset in the middle of EVAL
        RUN = 1'b1;
        OPCODE = 5'h10; TARGET = 11'h321; PC_IN = 11'h040;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1; chk_quiet("are_eval", 1'b1);
        #3;
        RESET_N = 1'b0;
        #1;
        chk_reset("are_now");
        @(posedge CLK); #1;
        chk_reset("are_held");
        RESET_N = 1'b1;
        // Restart: FETCH one cycle after RUN is seen, WPC on the 4th edge
        run_instr(mk(5'h10, 4'h0, 11'h321, 11'h040, 4'b0000, 4'b0000, 0, 1, 11'h321), "are_restart");

        // Asynchronous reset during UPDATE drops WPC at once
        #3;
        RESET_N = 1'b0;
        #1;
        chk_reset("aru_now");
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        // HALT: terminal, no WPC while RUN stays high
        RUN = 1'b1;
        OPCODE = 5'h1F; COND = 4'h0; TARGET = 11'h111; PC_IN = 11'h060; FLAGS = 4'b1111;
        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK); #1; chk_quiet($sformatf("halt_c%0d", k), 1'b1);
        end
        OPCODE = 5'h00;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK); #1;
            chk($sformatf("halt%0d_halted", k), HALTED,    1);
            chk($sformatf("halt%0d_busy", k),   BUSY,      0);
            chk($sformatf("halt%0d_wpc", k),    WPC,       0);
            chk($sformatf("halt%0d_uc", k),     UC_JMP,    0);
            chk($sformatf("halt%0d_dout", k),   DOUT,      0);
            chk($sformatf("halt%0d_state", k),  state_dbg, 5);
        end

        // Reset leaves HALT
        do_reset("reset_halt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
